// File: rtl/cache_pkg.sv
// Shared cache-system definitions.
// Contents:
//   BLOCK_SIZE / ADDRESS_WIDTH  default geometry of a cache block and of byte addresses
//   block_t                     one cache block of data
//   mem_state_e                 main-memory responder FSM states
//   offset_bits()               byte-offset width for a given block size
package cache_pkg;

    localparam int unsigned BLOCK_SIZE    = 32;
    localparam int unsigned ADDRESS_WIDTH = 32;

    typedef logic [8*BLOCK_SIZE-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_WAIT,
        READ_WAIT,
        DONE
    } mem_state_e;

    function automatic int unsigned offset_bits(input int unsigned block_size);
        return $clog2(block_size);
    endfunction

endpackage

// File: rtl/block_store.sv
// Block-granular backing store: DEPTH entries of DATA_WIDTH bits.
// Kept separate so an SRAM macro or a preloaded model can replace it.
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset (clears only the read register, not the array)
//   we     in   write enable, writes wdata to waddr on the rising edge
//   waddr  in   write index
//   wdata  in   write data
//   re     in   read enable, registers mem[raddr] into rdata on the rising edge
//   raddr  in   read index
//   rdata  out  registered read data, holds its value while re=0
module block_store #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side end of the cache controller link. Serves one block fetch or one dirty-line
// write-back at a time after a fixed latency, answering with a one-cycle done pulse.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   fetchReq          fetch request, held by the controller until fetchDone
//   fetchAddress      byte address of the block to fetch
//   fetchedData       block data, valid while fetchDone=1, holds afterwards
//   fetchDone         one-cycle fetch completion pulse
//   writeBackReq      write-back request, held until writeBackDone
//   writeBackAddress  byte address of the evicted block
//   writeBackData     evicted block data
//   writeBackDone     one-cycle write completion pulse
//   busy              high whenever the FSM is not IDLE
module main_memory_responder
    import cache_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE    = cache_pkg::BLOCK_SIZE,
    parameter int unsigned ADDRESS_WIDTH = cache_pkg::ADDRESS_WIDTH,
    parameter int unsigned MEM_BLOCKS    = 256,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetchReq,
    input  logic [ADDRESS_WIDTH-1:0] fetchAddress,
    output logic [8*BLOCK_SIZE-1:0]  fetchedData,
    output logic                     fetchDone,
    input  logic                     writeBackReq,
    input  logic [ADDRESS_WIDTH-1:0] writeBackAddress,
    input  logic [8*BLOCK_SIZE-1:0]  writeBackData,
    output logic                     writeBackDone,
    output logic                     busy
);

    localparam int unsigned DATA_W   = 8 * BLOCK_SIZE;
    localparam int unsigned OFF_BITS = offset_bits(BLOCK_SIZE);
    localparam int unsigned IDX_BITS = $clog2(MEM_BLOCKS);
    localparam int unsigned MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                      : WRITE_LATENCY;
    localparam int unsigned CNT_W    = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LATENCY - 1);

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  wb_done_q, wb_done_d;
    logic                  st_we, st_re;

    // Offset and upper address bits are intentionally dropped (upper bits alias).
    logic unused_addr;
    assign unused_addr = ^{fetchAddress, writeBackAddress};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            fetch_done_q <= 1'b0;
            wb_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            fetch_done_q <= fetch_done_d;
            wb_done_q    <= wb_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        fetch_done_d = 1'b0;
        wb_done_d    = 1'b0;
        st_we        = 1'b0;
        st_re        = 1'b0;
        case (state_q)
            IDLE: begin
                // Write-back first so a refill of the same block sees the evicted data.
                if (writeBackReq) begin
                    idx_d   = writeBackAddress[OFF_BITS +: IDX_BITS];
                    wdata_d = writeBackData;
                    cnt_d   = WR_INIT;
                    state_d = WRITE_WAIT;
                end else if (fetchReq) begin
                    idx_d   = fetchAddress[OFF_BITS +: IDX_BITS];
                    cnt_d   = RD_INIT;
                    state_d = READ_WAIT;
                end
            end
            WRITE_WAIT: begin
                if (cnt_q == '0) begin
                    st_we     = 1'b1;
                    wb_done_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            READ_WAIT: begin
                if (cnt_q == '0) begin
                    st_re        = 1'b1;
                    fetch_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // One turnaround cycle so a request held until its done pulse is not re-accepted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    block_store #(
        .DATA_WIDTH(DATA_W),
        .DEPTH     (MEM_BLOCKS),
        .ADDR_WIDTH(IDX_BITS)
    ) u_store (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (st_we),
        .waddr(idx_q),
        .wdata(wdata_q),
        .re   (st_re),
        .raddr(idx_q),
        .rdata(fetchedData)
    );

    assign fetchDone     = fetch_done_q;
    assign writeBackDone = wb_done_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: the driver pushes expected completions
// (data and completion cycle) from a transaction-level model; a negedge monitor pops and compares.
module tb_main_memory_responder;

    localparam int RL = 4;
    localparam int WL = 2;
    localparam int NBLK = 256;
    localparam int BSZ = 32;

    typedef struct {
        logic [255:0] data;
        int           due;
    } f_exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         fetchReq = 1'b0;
    logic [31:0]  fetchAddress = '0;
    logic [255:0] fetchedData;
    logic         fetchDone;
    logic         writeBackReq = 1'b0;
    logic [31:0]  writeBackAddress = '0;
    logic [255:0] writeBackData = '0;
    logic         writeBackDone;
    logic         busy;

    int compared = 0;
    int failed = 0;
    int cyc = 0;
    int idle_from = 0;

    f_exp_t       f_q[$];
    int           wb_q[$];
    logic [255:0] mem_model [int];

    main_memory_responder #(
        .BLOCK_SIZE   (BSZ),
        .ADDRESS_WIDTH(32),
        .MEM_BLOCKS   (NBLK),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetchReq        (fetchReq),
        .fetchAddress    (fetchAddress),
        .fetchedData     (fetchedData),
        .fetchDone       (fetchDone),
        .writeBackReq    (writeBackReq),
        .writeBackAddress(writeBackAddress),
        .writeBackData   (writeBackData),
        .writeBackDone   (writeBackDone),
        .busy            (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_int(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int blk_of(input logic [31:0] a);
        return int'((a / BSZ) % NBLK);
    endfunction

    function automatic logic [255:0] rand_blk();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input int blk);
        logic [31:0] a;
        a = $urandom;
        a[12:5] = 8'(blk);
        return a;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        f_exp_t e;
        if (rst_n) begin
            if (fetchDone) begin
                if (f_q.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL fetch_unexpected: fetchDone=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = f_q.pop_front();
                    chk_blk("fetch_data", fetchedData, e.data);
                    chk_int("fetch_cycle", cyc, e.due);
                end
            end
            if (writeBackDone) begin
                if (wb_q.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL wb_unexpected: writeBackDone=1 at cycle %0d, expected 0", cyc);
                end else begin
                    chk_int("wb_cycle", cyc, wb_q.pop_front());
                end
            end
        end
    end

    // Transaction-level model: the responder serves one request at a time, a write-back before
    // a simultaneous fetch; done arrives latency edges after accept, then one turnaround cycle.
    task automatic issue(input bit do_wb, input bit do_f, input logic [31:0] wa,
                         input logic [255:0] wd, input logic [31:0] fa);
        int n, acc, budget;
        f_exp_t e;
        @(negedge clk);
        n = cyc;
        if (do_wb) begin
            writeBackReq = 1'b1;
            writeBackAddress = wa;
            writeBackData = wd;
            acc = max2(n + 1, idle_from + 1);
            mem_model[blk_of(wa)] = wd;
            wb_q.push_back(acc + WL);
            idle_from = acc + WL + 1;
        end
        if (do_f) begin
            fetchReq = 1'b1;
            fetchAddress = fa;
            acc = max2(n + 1, idle_from + 1);
            e.data = mem_model[blk_of(fa)];
            e.due = acc + RL;
            f_q.push_back(e);
            idle_from = acc + RL + 1;
        end
        budget = 0;
        while ((writeBackReq || fetchReq) && budget < 40) begin
            @(negedge clk);
            budget++;
            if (writeBackDone) begin
                writeBackReq = 1'b0;
                writeBackAddress = $urandom;
            end
            if (fetchDone) begin
                fetchReq = 1'b0;
                fetchAddress = $urandom;
            end
        end
        if (writeBackReq || fetchReq) begin
            compared++;
            failed++;
            $display("FAIL handshake_timeout: request still pending after %0d cycles, expected done",
                     budget);
            writeBackReq = 1'b0;
            fetchReq = 1'b0;
        end
    endtask

    // Fetch held high across three addresses; busy must drop only in the IDLE cycle between.
    task automatic fetch_chain(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        logic [31:0] addrs [3];
        int k, budget, gap;
        f_exp_t e;
        addrs[0] = a0;
        addrs[1] = a1;
        addrs[2] = a2;
        @(negedge clk);
        fetchReq = 1'b1;
        fetchAddress = addrs[0];
        e.data = mem_model[blk_of(addrs[0])];
        e.due = max2(cyc + 1, idle_from + 1) + RL;
        f_q.push_back(e);
        idle_from = e.due + 1;
        gap = -1;
        k = 0;
        budget = 0;
        while (fetchReq && budget < 60) begin
            @(negedge clk);
            budget++;
            chk_int("chain_busy", int'(busy), (cyc == gap) ? 0 : 1);
            if (fetchDone) begin
                k++;
                if (k < 3) begin
                    fetchAddress = addrs[k];
                    gap = idle_from;
                    e.data = mem_model[blk_of(addrs[k])];
                    e.due = max2(cyc + 1, idle_from + 1) + RL;
                    f_q.push_back(e);
                    idle_from = e.due + 1;
                end else begin
                    fetchReq = 1'b0;
                end
            end
        end
        if (fetchReq) begin
            compared++;
            failed++;
            $display("FAIL chain_timeout: %0d of 3 fetches completed, expected 3", k);
            fetchReq = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] pa, pb, pc;
        int kind, bw, bf;

        // 1: reset values
        #2 rst_n = 1'b0;
        #1;
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_fetchDone", int'(fetchDone), 0);
        chk_int("rst_wbDone", int'(writeBackDone), 0);
        chk_blk("rst_fetchedData", fetchedData, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_from = cyc;

        // 2: write then read with nonzero offset
        pa = rand_blk();
        issue(1'b1, 1'b0, 32'h0000_0040, pa, '0);
        issue(1'b0, 1'b1, '0, '0, 32'h0000_0047);

        // 3: simultaneous requests to the same block
        pb = rand_blk();
        issue(1'b1, 1'b1, 32'h0000_0080, pb, 32'h0000_0080);

        // 4: address wrap modulo MEM_BLOCKS
        pc = rand_blk();
        issue(1'b1, 1'b0, 32'h0000_0000, pc, '0);
        issue(1'b0, 1'b1, '0, '0, 32'h0000_2000);

        // Populate a small working set for the random phase.
        for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, mk_addr(i), rand_blk(), '0);

        // 6: back-to-back held fetch
        fetch_chain(mk_addr(3), mk_addr(7), 32'h0000_0047);

        // 5: reset in READ_WAIT, fetchedData is nonzero here
        @(negedge clk);
        fetchReq = 1'b1;
        fetchAddress = mk_addr(5);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_int("midrst_busy", int'(busy), 0);
        chk_int("midrst_fetchDone", int'(fetchDone), 0);
        chk_blk("midrst_fetchedData", fetchedData, '0);
        @(negedge clk);
        fetchReq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_from = cyc;
        repeat (8) @(negedge clk);
        chk_int("post_rst_idle", int'(busy), 0);
        issue(1'b0, 1'b1, '0, '0, mk_addr(5));

        // Random traffic over the working set
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            bw = $urandom_range(0, 15);
            bf = $urandom_range(0, 15);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(kind != 1, kind != 0, mk_addr(bw), rand_blk(), mk_addr(bf));
        end

        repeat (5) @(negedge clk);
        chk_int("queues_drained", f_q.size() + wb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
